// File: rtl/axis_burst_gen.sv
// AXI-Stream burst generator: LEN-beat bursts of a run-relative ramp, GAP idle cycles
// between bursts, NBURST bursts per run (0 = until stopped).
module axis_burst_gen #(
  parameter int AXIS_OUT_DW = 32,
  parameter int LEN_W       = 32,
  parameter int NB_W        = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [LEN_W-1:0]       len_i,
  input  logic [LEN_W-1:0]       gap_i,
  input  logic [NB_W-1:0]        nburst_i,
  output logic [AXIS_OUT_DW-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [NB_W-1:0]        burst_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] gap_q;
  logic [NB_W-1:0]  nburst_q;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] gap_cnt;
  logic             stop_pend;

  logic             xfer;
  logic             stop_now;
  logic             run_end;
  logic [NB_W-1:0]  burst_next;
  logic [LEN_W-1:0] beat_next;
  logic             first_last;
  logic             gap_done;

  // Next-state helpers; a stop arriving in the same cycle as the decision point counts as pending.
  always_comb begin
    xfer       = m_axis_tvalid & m_axis_tready;
    stop_now   = stop_pend | stop_i;
    burst_next = burst_cnt_o + NB_W'(1);
    beat_next  = beat_cnt + LEN_W'(1);
    first_last = (len_q == LEN_W'(1));
    gap_done   = (gap_cnt == (gap_q - LEN_W'(1)));
    if ((nburst_q != '0) && (burst_next == nburst_q)) begin
      run_end = 1'b1;
    end else begin
      run_end = stop_now;
    end
  end

  // Burst FSM with all stream and status outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      len_q         <= '0;
      gap_q         <= '0;
      nburst_q      <= '0;
      beat_cnt      <= '0;
      gap_cnt       <= '0;
      stop_pend     <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      burst_cnt_o   <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          stop_pend <= 1'b0;
          if (start_i && (len_i != '0)) begin
            len_q         <= len_i;
            gap_q         <= gap_i;
            nburst_q      <= nburst_i;
            beat_cnt      <= '0;
            gap_cnt       <= '0;
            burst_cnt_o   <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (len_i == LEN_W'(1));
            busy_o        <= 1'b1;
            state         <= ST_BURST;
          end
        end

        ST_BURST: begin
          stop_pend <= stop_now;
          if (xfer) begin
            m_axis_tdata <= m_axis_tdata + AXIS_OUT_DW'(1);
            if (m_axis_tlast) begin
              burst_cnt_o <= burst_next;
              beat_cnt    <= '0;
              if (run_end) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                busy_o        <= 1'b0;
                done_o        <= 1'b1;
                stop_pend     <= 1'b0;
                state         <= ST_IDLE;
              end else if (gap_q != '0) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                gap_cnt       <= '0;
                state         <= ST_GAP;
              end else begin
                // back-to-back: tvalid stays high into the next burst
                m_axis_tlast <= first_last;
              end
            end else begin
              beat_cnt     <= beat_next;
              m_axis_tlast <= (beat_next == (len_q - LEN_W'(1)));
            end
          end
        end

        ST_GAP: begin
          if (stop_now) begin
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            stop_pend <= 1'b0;
            state     <= ST_IDLE;
          end else if (gap_done) begin
            beat_cnt      <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= first_last;
            state         <= ST_BURST;
          end else begin
            gap_cnt <= gap_cnt + LEN_W'(1);
          end
        end

        default: begin
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
          busy_o        <= 1'b0;
          stop_pend     <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
